tea_engine: RTL
===============

# tea_engine

Parametrised TEA block-cipher engine, the next generation of the team's 16-bit single-mode TEA FSM. It accepts a plaintext/ciphertext pair and a 128-bit key (four words) on a start pulse, and runs one Feistel half-round per clock. It returns the result with a one-cycle done pulse. Word width, round count and delta are parameters, and decryption is a compile-time option. It sits between the crypto register file and the DMA/packet datapath.

## Interface
- WORD_SIZE, 32, data/key word width; all arithmetic is modulo 2^WORD_SIZE.
- ROUNDS, 32, full TEA cycles per block; must be ≥1.
- DELTA, 32'h9e3779b9, key-schedule constant; truncated to WORD_SIZE low bits.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- iStart  in  1  request pulse; accepted only when oReady=1.
- iDecrypt  in  1  mode sampled at accept: 0 = encrypt, 1 = decrypt.
- iV0, iV1  in  WORD_SIZE each  input block, sampled at accept.
- iK0..iK3  in  WORD_SIZE each  key words, sampled at accept.
- oC0, oC1  out  WORD_SIZE each  result block, held until the next accept.
- oReady  out  1  high in IDLE only.
- oDone  out  1  one-cycle pulse when oC0/oC1 are valid.

## Operation
- States: IDLE, HALF0, HALF1, DONE.
  - IDLE→HALF0 on iStart.
  - HALF0→HALF1 always.
  - HALF1→HALF0 while the round counter is below ROUNDS-1; otherwise HALF1→DONE.
  - DONE→IDLE always.
- Accept (IDLE & iStart):
  - Latch iV0/iV1 into v0/v1, latch the key, latch the mode, clear the round counter.
  - sum = DELTA for encrypt; sum = DELTA*ROUNDS mod 2^WORD_SIZE for decrypt.
- F(x, ka, kb) = ((x<<4)+ka) ^ (x+sum) ^ ((x>>5)+kb), where shifts are logical within WORD_SIZE.
- Encrypt:
  - HALF0: v0 += F(v1, k0, k1).
  - HALF1: v1 += F(v0, k2, k3); then sum += DELTA and the counter increments.
- Decrypt:
  - HALF0: v1 -= F(v0, k2, k3).
  - HALF1: v0 -= F(v1, k0, k1); then sum -= DELTA and the counter increments.
- oC0/oC1 are driven directly from v0/v1. They change during computation and are valid only when oDone=1. They then hold until the next accept.
- iStart outside IDLE is ignored, including during DONE. No queueing.
- Input ports are not tracked after accept; changes to them mid-operation have no effect.
- Reset values: state IDLE, v0/v1/oC0/oC1 = 0, sum = 0, counter = 0, oDone = 0, oReady = 1.
- Reset mid-operation aborts immediately with no done pulse.

## Timing
- Accept edge = cycle 0. Half-rounds occupy cycles 1..2*ROUNDS.
- oDone is high during cycle 2*ROUNDS+1 (DONE); oReady returns high in the following cycle.
- Latency from accept to oDone = 2*ROUNDS+1 cycles: 65 at ROUNDS=32.
- Back-to-back throughput is one block per 2*ROUNDS+2 cycles.
- Round counter width is $clog2(ROUNDS+1). The last-round comparison must not wrap when ROUNDS is a power of two.
- Critical path is one adder chain, F then add/sub, at WORD_SIZE.

## Configuration
- TEA_DECRYPT_EN defined: decrypt datapath and the DELTA*ROUNDS initial-sum constant are compiled in, and iDecrypt selects the mode.
- TEA_DECRYPT_EN undefined: encrypt-only. The iDecrypt port remains but is ignored, and no subtractor or decrypt constant is built.

## Structure
- Package tea_pkg holds:
  - the state enum (IDLE, HALF0, HALF1, DONE);
  - TEA_DELTA_DEFAULT;
  - a function computing the decrypt initial sum (DELTA*ROUNDS truncated).
- One combinational sub-module, tea_feistel_f, computes F(x, ka, kb, sum) at WORD_SIZE and is instantiated once.
- The FSM and the add/sub select stay in tea_engine.

## Test plan
- Reset → oReady=1, oDone=0, oC0=oC1=0. Assert rst mid-run at cycle 20 → immediate IDLE, no oDone pulse.
- Encrypt, WORD_SIZE=32, ROUNDS=32, key 0, V=(0,0) → oDone at cycle 65 with oC0=0x41EA3A0A, oC1=0x94BAA940.
- With TEA_DECRYPT_EN: decrypt (0x41EA3A0A, 0x94BAA940) under key 0 → (0,0) at cycle 65. Repeat the round trip for 100 random key/blocks against a C model.
- Without TEA_DECRYPT_EN: iDecrypt=1 with V=(0,0), key 0 → same result as the encrypt case (0x41EA3A0A, 0x94BAA940).
- iStart held high continuously → accepts at cycles 0, 66, 132; starts during busy and DONE cycles are ignored; outputs stable between oDone and the next accept.
- Encrypt with WORD_SIZE=16, ROUNDS=8, DELTA low 16 bits 0x79B9 → oDone at cycle 17, matching the 16-bit C model; boundary case ROUNDS=1 → oDone at cycle 3.

Source files
------------

// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA engine: FSM state encoding,
// the default key-schedule constant and the decrypt initial-sum helper.
package tea_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALF0 = 2'd1,
    HALF1 = 2'd2,
    DONE  = 2'd3
  } tea_state_t;

  localparam logic [31:0] TEA_DELTA_DEFAULT = 32'h9e3779b9;

  // Decryption starts from the sum encryption would reach after the last round.
  function automatic logic [63:0] tea_decrypt_sum(input logic [63:0] delta,
                                                   input int unsigned rounds);
    return delta * 64'(rounds);
  endfunction

endpackage

// File: rtl/tea_feistel_f.sv
// TEA round function F(x, ka, kb, sum) at WORD_SIZE bits; purely combinational,
// shifts are logical and all additions wrap modulo 2^WORD_SIZE.
module tea_feistel_f #(
  parameter int WORD_SIZE = 32
) (
  input  logic [WORD_SIZE-1:0] x,
  input  logic [WORD_SIZE-1:0] ka,
  input  logic [WORD_SIZE-1:0] kb,
  input  logic [WORD_SIZE-1:0] sum,
  output logic [WORD_SIZE-1:0] f
);

  logic [WORD_SIZE-1:0] term_shl;
  logic [WORD_SIZE-1:0] term_sum;
  logic [WORD_SIZE-1:0] term_shr;

  always_comb begin
    term_shl = (x << 4) + ka;
    term_sum = x + sum;
    term_shr = (x >> 5) + kb;
    f        = term_shl ^ term_sum ^ term_shr;
  end

endmodule

// File: rtl/tea_engine.sv
// Iterative TEA block cipher, one Feistel half-round per clock.
// Define TEA_DECRYPT_EN to build the decrypt datapath; otherwise iDecrypt is ignored.
//
// Handshake: a block is accepted on a rising edge where iStart=1 and oReady=1
// (oReady is high only in IDLE); oDone pulses for exactly one cycle when oC0/oC1
// hold the result, which then stays stable until the next accept.
module tea_engine
  import tea_pkg::*;
#(
  parameter int          WORD_SIZE = 32,
  parameter int          ROUNDS    = 32,
  parameter logic [31:0] DELTA     = TEA_DELTA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic                 iDecrypt,
  input  logic [WORD_SIZE-1:0] iV0,
  input  logic [WORD_SIZE-1:0] iV1,
  input  logic [WORD_SIZE-1:0] iK0,
  input  logic [WORD_SIZE-1:0] iK1,
  input  logic [WORD_SIZE-1:0] iK2,
  input  logic [WORD_SIZE-1:0] iK3,
  output logic [WORD_SIZE-1:0] oC0,
  output logic [WORD_SIZE-1:0] oC1,
  output logic                 oReady,
  output logic                 oDone,
  output tea_state_t           dbg_state
);

  localparam int                   CNT_W    = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(ROUNDS - 1);
  localparam logic [WORD_SIZE-1:0] DELTA_W  = WORD_SIZE'(DELTA);

  tea_state_t state;
  tea_state_t next_state;

  logic [WORD_SIZE-1:0] v0, v1;
  logic [WORD_SIZE-1:0] key0, key1, key2, key3;
  logic [WORD_SIZE-1:0] sum;
  logic [CNT_W-1:0]     cnt;
  logic                 dec;

  logic                 use_hi;
  logic                 last_round;
  logic [WORD_SIZE-1:0] f_x, f_ka, f_kb, f_out;
  logic [WORD_SIZE-1:0] target, updated;

`ifdef TEA_DECRYPT_EN
  localparam logic [WORD_SIZE-1:0] DEC_SUM =
    WORD_SIZE'(tea_decrypt_sum(64'(DELTA), ROUNDS));
`else
  logic unused_decrypt;
  assign dec            = 1'b0;
  assign unused_decrypt = iDecrypt;
`endif

  // Equality against the last index keeps the compare from wrapping when ROUNDS is 2^n.
  assign last_round = (cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (iStart) next_state = HALF0;
      HALF0:   next_state = HALF1;
      HALF1:   next_state = last_round ? DONE : HALF0;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // use_hi selects the (v0, k2, k3) operand set; the word not fed to F is the one updated.
  always_comb begin
    use_hi = (state == HALF1) ^ dec;
    f_x    = use_hi ? v0   : v1;
    f_ka   = use_hi ? key2 : key0;
    f_kb   = use_hi ? key3 : key1;
    target = use_hi ? v1   : v0;
`ifdef TEA_DECRYPT_EN
    updated = dec ? (target - f_out) : (target + f_out);
`else
    updated = target + f_out;
`endif
  end

  tea_feistel_f #(
    .WORD_SIZE(WORD_SIZE)
  ) u_feistel (
    .x  (f_x),
    .ka (f_ka),
    .kb (f_kb),
    .sum(sum),
    .f  (f_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0   <= '0;
      v1   <= '0;
      key0 <= '0;
      key1 <= '0;
      key2 <= '0;
      key3 <= '0;
      sum  <= '0;
      cnt  <= '0;
`ifdef TEA_DECRYPT_EN
      dec  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            v0   <= iV0;
            v1   <= iV1;
            key0 <= iK0;
            key1 <= iK1;
            key2 <= iK2;
            key3 <= iK3;
            cnt  <= '0;
`ifdef TEA_DECRYPT_EN
            dec  <= iDecrypt;
            sum  <= iDecrypt ? DEC_SUM : DELTA_W;
`else
            sum  <= DELTA_W;
`endif
          end
        end
        HALF0, HALF1: begin
          if (use_hi) v1 <= updated;
          else        v0 <= updated;
          if (state == HALF1) begin
            cnt <= cnt + CNT_W'(1);
`ifdef TEA_DECRYPT_EN
            sum <= dec ? (sum - DELTA_W) : (sum + DELTA_W);
`else
            sum <= sum + DELTA_W;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign oC0       = v0;
  assign oC1       = v1;
  assign oReady    = (state == IDLE);
  assign oDone     = (state == DONE);
  assign dbg_state = state;

endmodule
